// File: rtl/skid_buffer_pkg.sv
// Shared types and constants for the skid buffer.
// The optional counters are enabled by the SKID_BUFFER_STATS_EN macro.
package skid_buffer_pkg;

  typedef enum logic [1:0] {
    Empty = 2'd0,
    Busy  = 2'd1,
    Full  = 2'd2
  } state_e;

  localparam int StatsWidth = 32;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
// It is used for the optional skid buffer statistics.
module sat_counter #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer. All outputs are driven by flops.
// Defining SKID_BUFFER_STATS_EN adds the beats_o and stalls_o counters.
module skid_buffer
  import skid_buffer_pkg::*;
#(
  parameter int Width         = 8,
  parameter bit DatapathReset = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  input  logic             ready_i
`ifdef SKID_BUFFER_STATS_EN
  ,
  output logic [StatsWidth-1:0] beats_o,
  output logic [StatsWidth-1:0] stalls_o
`endif
);

  state_e           state_q, state_d;
  logic             ready_q;
  logic [Width-1:0] main_q, skid_q, main_d;
  logic             in_fire, out_fire;
  logic             load_main, load_skid, main_from_skid, main_en;

  assign in_fire  = valid_i && ready_o;
  assign out_fire = valid_o && ready_i;

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      Empty: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_d   = Busy;
        end
      end
      Busy: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = Full;
        end else if (out_fire) begin
          state_d   = Empty;
        end
      end
      Full: begin
        // The upstream is stalled here, so valid_i plays no part.
        if (out_fire) begin
          main_from_skid = 1'b1;
          state_d        = Busy;
        end
      end
      default: state_d = Empty;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Empty;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Registering on the next state keeps ready_o free of any input path.
      ready_q <= (state_d != Full);
    end
  end

  assign main_en = load_main || main_from_skid;
  assign main_d  = main_from_skid ? skid_q : data_i;

  if (DatapathReset) begin : g_dp_rst
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        if (main_en)   main_q <= main_d;
        if (load_skid) skid_q <= data_i;
      end
    end
  end else begin : g_dp_norst
    always_ff @(posedge clk_i) begin
      if (main_en)   main_q <= main_d;
      if (load_skid) skid_q <= data_i;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = (state_q == Busy) || (state_q == Full);
  assign data_o  = main_q;

`ifdef SKID_BUFFER_STATS_EN
  sat_counter #(.Width(StatsWidth)) u_beats (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (out_fire),
    .count_o (beats_o)
  );

  sat_counter #(.Width(StatsWidth)) u_stalls (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (valid_o && !ready_i),
    .count_o (stalls_o)
  );
`endif

endmodule

// File: doc/skid_buffer.md
SKID_BUFFER -- requirements
Module: skid_buffer

Interface
REQ-001 The block SHALL have parameter Width, default 8, giving the payload width in bits (>=1).
REQ-002 The block SHALL have parameter DatapathReset, default 0; when 1, data registers are cleared by reset.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 data_i  input  Width  upstream payload.
REQ-006 valid_i  input  1  upstream payload valid.
REQ-007 ready_o  output  1  upstream may transfer; driven directly by a flop.
REQ-008 valid_o  output  1  downstream payload valid.
REQ-009 data_o  output  Width  downstream payload.
REQ-010 ready_i  input  1  downstream accepts.
REQ-011 With SKID_BUFFER_STATS_EN defined, the block SHALL add beats_o (output, 32 bits, count of downstream transfers) and stalls_o (output, 32 bits, count of cycles with valid_o=1 and ready_i=0).

Function
REQ-012 in_fire = valid_i && ready_o; out_fire = valid_o && ready_i.
REQ-013 The block SHALL hold a main register and a skid register, with states Empty (0 items), Busy (main holds 1 item) and Full (main and skid hold 1 item each).
REQ-014 Empty: on in_fire, main<=data_i and go to Busy; otherwise stay in Empty.
REQ-015 Busy: on in_fire&&out_fire, main<=data_i and stay in Busy; on in_fire only, skid<=data_i and go to Full; on out_fire only, go to Empty; otherwise stay in Busy.
REQ-016 Full: on out_fire, main<=skid and go to Busy; otherwise stay in Full; valid_i is ignored.
REQ-017 valid_o SHALL be 1 exactly in Busy and Full; data_o SHALL equal main.
REQ-018 ready_o SHALL be registered as (next state != Full), so ready_o has no combinational path from ready_i or valid_i.
REQ-019 valid_o and data_o SHALL have no combinational path from any input.
REQ-020 Latency SHALL be 1 cycle from in_fire to valid_o; sustained throughput SHALL be 1 beat per cycle when ready_i is held at 1.
REQ-021 Beats SHALL leave in acceptance order, with no loss or duplication.
REQ-022 While valid_o=1 and ready_i=0, data_o SHALL stay stable.
REQ-023 An unreachable state encoding SHALL transition to Empty.

Reset
REQ-024 While rst_ni=0, the block SHALL be in Empty, with valid_o=0 and ready_o=0.
REQ-025 ready_o SHALL rise at the first clk_i edge after rst_ni deasserts.
REQ-026 Main and skid SHALL reset to 0 only when DatapathReset=1; otherwise they SHALL be unreset.
REQ-027 Reset mid-transfer SHALL discard all held beats, with no partial output.

Configuration
REQ-028 With SKID_BUFFER_STATS_EN defined, beats_o and stalls_o SHALL each reset to 0, increment by 1 per qualifying cycle, and saturate at 32'hFFFF_FFFF.
REQ-029 Without SKID_BUFFER_STATS_EN, neither port nor any counter logic SHALL exist, and datapath behaviour SHALL be identical to the enabled build.

Structure
REQ-030 Package skid_buffer_pkg SHALL hold the state enum (Empty, Busy, Full) and the constant StatsWidth=32.
REQ-031 Sub-module sat_counter (parameter Width; ports clk_i, rst_ni, inc_i, count_o) SHALL be instantiated twice when stats are enabled.

Verification
REQ-032 Reset released, valid_i=1, data_i=8'hA5, ready_i=1 -> ready_o=1 one cycle after release; valid_o=1 with data_o=A5 one cycle after in_fire.
REQ-033 Continuous stream 0..15 with ready_i=1 -> 16 output beats on 16 consecutive cycles, in order, and ready_o never drops.
REQ-034 Beats 1,2 sent with ready_i=0 -> state Full, ready_o=0, data_o=1 stable; ready_i=1 -> outputs 1 then 2, and ready_o returns to 1.
REQ-035 Random valid_i and ready_i over 10k cycles -> the output sequence equals the input sequence, and ready_o never depends combinationally on ready_i.
REQ-036 rst_ni pulsed low while Full -> valid_o=0 and ready_o=0 immediately (asynchronously); no stale beat appears after release.
REQ-037 STATS_EN build, 5 beats with 3 stall cycles -> beats_o=5 and stalls_o=3; a counter preloaded to max stays at FFFF_FFFF.
